ethernet_hub_repeater: RTL and testbench
========================================

ETHERNET_HUB_REPEATER -- requirements
Module: ethernet_hub_repeater

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of hub ports (legal 2..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, bytes per ingress FIFO (power of 2, 4..256).
REQ-003 SHALL have parameter CNT_W, default 16, width of statistics counters.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port rx_data  input  8*NUM_PORTS  ingress byte per port; port p at bits [8p+7:8p].
REQ-007 SHALL have port rx_valid  input  NUM_PORTS  ingress byte valid per port.
REQ-008 SHALL have port rx_last  input  NUM_PORTS  marks final byte of a frame.
REQ-009 SHALL have port rx_ready  output  NUM_PORTS  ingress FIFO not full.
REQ-010 SHALL have port tx_data  output  8  broadcast egress byte.
REQ-011 SHALL have port tx_last  output  1  marks final egress byte.
REQ-012 SHALL have port tx_valid  output  NUM_PORTS  per-port egress valid; source port bit always 0.
REQ-013 SHALL have port tx_ready  input  NUM_PORTS  per-port egress ready.
REQ-014 SHALL have port collision_cnt  output  CNT_W  arbitration contention count.
REQ-015 SHALL have port drop_cnt  output  CNT_W  frames discarded on overflow.

Function
REQ-016 SHALL accept an ingress byte on port p when rx_valid[p] and rx_ready[p] are both 1 in the same cycle.
REQ-017 SHALL keep per-port write pointer, committed write pointer, read pointer and committed-frame count; rx_ready[p] = FIFO not full.
REQ-018 SHALL, on accepted byte with rx_last=1, advance committed pointer to new write pointer and increment frame count in the same edge.
REQ-019 SHALL, when rx_valid[p]=1 while FIFO full, enter per-port DROP mode: rewind write pointer to committed pointer, discard bytes until a byte with rx_last=1 is presented, then increment drop_cnt once; in DROP, rx_ready[p]=1.
REQ-020 SHALL run egress FSM IDLE -> ARB -> FWD -> IDLE.
REQ-021 IDLE: SHALL move to ARB when any port's frame count is nonzero.
REQ-022 ARB: SHALL grant the first eligible port searching round-robin from (last grant + 1) mod NUM_PORTS; grant pointer after reset = NUM_PORTS-1 (port 0 wins first); move to FWD next cycle.
REQ-023 ARB: SHALL increment collision_cnt by 1 when two or more ports are eligible.
REQ-024 FWD: SHALL drive tx_data/tx_last from head of granted FIFO and tx_valid = all ports except granted.
REQ-025 FWD: SHALL pop one byte only when tx_ready is 1 on every non-source port (backpressure all-or-nothing); otherwise hold outputs stable.
REQ-026 SHALL, on popping the tx_last byte, decrement granted frame count and return to IDLE; min frame-to-frame gap 2 cycles.
REQ-027 SHALL treat simultaneous commit (ingress) and frame-count decrement (egress) on one port as net zero change.
REQ-028 SHALL saturate collision_cnt and drop_cnt at 2^CNT_W-1.
REQ-029 SHALL wrap FIFO pointers modulo FIFO_DEPTH using one extra bit for full/empty distinction.
REQ-030 SHALL never forward an uncommitted (partial) frame.

Reset
REQ-031 SHALL, on reset=0, asynchronously clear: all pointers and frame counts, DROP flags, FSM to IDLE, grant pointer to NUM_PORTS-1, tx_valid=0, tx_data=0x00, tx_last=0, counters=0; rx_ready=all ones.
REQ-032 SHALL discard any frame in flight (ingress or egress) at reset assertion; no partial frame resumes after release.

Verification
REQ-033 Port 0 sends 3-byte frame 0x11,0x22,0x33 (last on 0x33), all tx_ready=1 -> tx_valid=4'b1110 for 3 cycles with those bytes, tx_last on 0x33, collision_cnt=0.
REQ-034 Ports 1 and 2 commit frames same cycle after reset -> port 1 forwarded first, then port 2; collision_cnt=1.
REQ-035 Port 3 sends 20 bytes without rx_last, FIFO_DEPTH=16 -> rx_ready[3] stays 1 in DROP, no egress, drop_cnt=1 after last byte, next 2-byte frame forwarded intact.
REQ-036 During FWD drop tx_ready[2] for 3 cycles -> tx_data/tx_last/tx_valid unchanged, no byte lost or duplicated.
REQ-037 Assert reset mid-FWD of a 10-byte frame after byte 4 -> all outputs at reset values immediately; after release, no egress until a new frame commits.
REQ-038 Force 2^CNT_W collisions (CNT_W=4 build) -> collision_cnt holds at 15.

Source files
------------

// File: rtl/ethernet_hub_repeater.sv
// Store-and-forward Ethernet hub: per-port ingress FIFOs with frame commit/drop,
// round-robin egress arbiter broadcasting one frame at a time to all other ports.
//
// state  | meaning
// S_IDLE | no frame in flight; waits for any committed frame
// S_ARB  | picks next port round-robin, counts contention
// S_FWD  | streams granted frame; pops only when every listener is ready
module ethernet_hub_repeater #(
    parameter int NUM_PORTS  = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [8*NUM_PORTS-1:0] rx_data,
    input  logic [NUM_PORTS-1:0]   rx_valid,
    input  logic [NUM_PORTS-1:0]   rx_last,
    output logic [NUM_PORTS-1:0]   rx_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_last,
    output logic [NUM_PORTS-1:0]   tx_valid,
    input  logic [NUM_PORTS-1:0]   tx_ready,
    output logic [CNT_W-1:0]       collision_cnt,
    output logic [CNT_W-1:0]       drop_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = $clog2(NUM_PORTS);

    typedef logic [AW:0] ptr_t;
    typedef enum logic [1:0] {S_IDLE, S_ARB, S_FWD} state_t;

    state_t state, state_nxt;

    logic [8:0] mem [NUM_PORTS][FIFO_DEPTH];
    ptr_t wptr [NUM_PORTS];
    ptr_t cptr [NUM_PORTS];
    ptr_t rptr [NUM_PORTS];
    ptr_t fcnt [NUM_PORTS];

    logic [NUM_PORTS-1:0] drop;
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] wr;
    logic [NUM_PORTS-1:0] commit;
    logic [NUM_PORTS-1:0] drop_enter;
    logic [NUM_PORTS-1:0] drop_done;
    logic [NUM_PORTS-1:0] elig;
    logic [NUM_PORTS-1:0] pop;
    logic [NUM_PORTS-1:0] pop_last;
    logic [NUM_PORTS-1:0] src_mask;

    logic [PW-1:0]    grant, grant_nxt;
    logic             found;
    logic             multi;
    logic             fwd;
    logic             all_ready;
    logic [8:0]       head;
    logic [CNT_W-1:0] drop_cnt_nxt;

    assign fwd       = (state == S_FWD);
    assign src_mask  = NUM_PORTS'(1) << grant;
    assign all_ready = &(tx_ready | src_mask);
    assign head      = mem[grant][rptr[grant][AW-1:0]];
    assign multi     = |(elig & (elig - NUM_PORTS'(1)));

    assign tx_valid  = fwd ? ~src_mask : '0;
    assign tx_data   = fwd ? head[7:0] : 8'h00;
    assign tx_last   = fwd & head[8];

    always_comb begin
        full       = '0;
        rx_ready   = '0;
        wr         = '0;
        commit     = '0;
        drop_enter = '0;
        drop_done  = '0;
        elig       = '0;
        pop        = '0;
        pop_last   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            full[p]       = (wptr[p][AW] != rptr[p][AW]) &&
                            (wptr[p][AW-1:0] == rptr[p][AW-1:0]);
            rx_ready[p]   = drop[p] | ~full[p];
            wr[p]         = rx_valid[p] & rx_ready[p] & ~drop[p];
            commit[p]     = wr[p] & rx_last[p];
            drop_enter[p] = rx_valid[p] & full[p] & ~drop[p];
            drop_done[p]  = rx_valid[p] & rx_last[p] & drop[p];
            elig[p]       = (fcnt[p] != '0);
            pop[p]        = fwd && (grant == PW'(p)) && all_ready;
            pop_last[p]   = pop[p] & head[8];
        end
    end

    // Round-robin search starting one past the previous grant.
    always_comb begin
        int idx;
        grant_nxt = grant;
        found     = 1'b0;
        idx       = 0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx = (int'(grant) + i) % NUM_PORTS;
            if (!found && elig[idx]) begin
                found     = 1'b1;
                grant_nxt = PW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (|elig) state_nxt = S_ARB;
            S_ARB:   state_nxt = found ? S_FWD : S_IDLE;
            S_FWD:   if (|pop_last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        drop_cnt_nxt = drop_cnt;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (drop_done[p] && drop_cnt_nxt != '1)
                drop_cnt_nxt = drop_cnt_nxt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            grant         <= PW'(NUM_PORTS - 1);
            collision_cnt <= '0;
            drop_cnt      <= '0;
        end else begin
            state    <= state_nxt;
            drop_cnt <= drop_cnt_nxt;
            if (state == S_ARB && found)
                grant <= grant_nxt;
            if (state == S_ARB && multi && collision_cnt != '1)
                collision_cnt <= collision_cnt + CNT_W'(1);
        end
    end

    // A drop rewinds to the last commit so the partial frame never becomes visible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                wptr[p] <= '0;
                cptr[p] <= '0;
                rptr[p] <= '0;
                fcnt[p] <= '0;
            end
            drop <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (drop_enter[p]) begin
                    wptr[p] <= cptr[p];
                    drop[p] <= 1'b1;
                end else if (drop_done[p]) begin
                    drop[p] <= 1'b0;
                end else if (wr[p]) begin
                    wptr[p] <= wptr[p] + ptr_t'(1);
                    if (rx_last[p])
                        cptr[p] <= wptr[p] + ptr_t'(1);
                end
                if (pop[p])
                    rptr[p] <= rptr[p] + ptr_t'(1);
                if (commit[p] && !pop_last[p])
                    fcnt[p] <= fcnt[p] + ptr_t'(1);
                else if (!commit[p] && pop_last[p])
                    fcnt[p] <= fcnt[p] - ptr_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (wr[p])
                mem[p][wptr[p][AW-1:0]] <= {rx_last[p], rx_data[8*p +: 8]};
        end
    end

endmodule

// File: tb/tb_ethernet_hub_repeater.sv
// Directed bench for ethernet_hub_repeater: table of single-port frames plus
// hand-written arbitration, drop, backpressure, reset and saturation sequences.
module tb_ethernet_hub_repeater;
    logic        clk;
    logic        reset;
    logic [31:0] rx_data;
    logic [3:0]  rx_valid;
    logic [3:0]  rx_last;
    logic [3:0]  rx_ready;
    logic [7:0]  tx_data;
    logic        tx_last;
    logic [3:0]  tx_valid;
    logic [3:0]  tx_ready;
    logic [3:0]  collision_cnt;
    logic [3:0]  drop_cnt;

    ethernet_hub_repeater #(.NUM_PORTS(4), .FIFO_DEPTH(16), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_last(tx_last), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .collision_cnt(collision_cnt), .drop_cnt(drop_cnt)
    );

    typedef struct {
        int         port;
        logic [7:0] data;
        logic       last;
        logic [3:0] exp_valid;
    } vec_t;

    vec_t        tbl [11];
    logic [12:0] obs_q [$];
    int          obs_cyc [$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every byte actually transferred (all listeners ready).
    always @(negedge clk) begin
        if (reset && (tx_valid != 4'b0000) && (&(tx_ready | ~tx_valid))) begin
            obs_q.push_back({tx_last, tx_valid, tx_data});
            obs_cyc.push_back(cyc);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int p, input logic [7:0] d, input logic l);
        rx_valid[p] = 1'b1;
        rx_data[8*p +: 8] = d;
        rx_last[p] = l;
        @(posedge clk); #1;
        rx_valid[p] = 1'b0;
        rx_last[p] = 1'b0;
    endtask

    task automatic push_pair(input int p, input int q, input logic [7:0] dp,
                             input logic [7:0] dq, input logic l);
        rx_valid[p] = 1'b1; rx_data[8*p +: 8] = dp; rx_last[p] = l;
        rx_valid[q] = 1'b1; rx_data[8*q +: 8] = dq; rx_last[q] = l;
        @(posedge clk); #1;
        rx_valid = 4'b0000;
        rx_last  = 4'b0000;
    endtask

    task automatic drain(input int n);
        int k = 0;
        while (obs_q.size() < n && k < 200) begin
            @(posedge clk);
            k++;
        end
        repeat (6) @(posedge clk);
        #1;
        check("egress_count", 32'(obs_q.size()), 32'(n));
    endtask

    task automatic expect_byte(input string name, input logic [7:0] d, input logic l,
                               input logic [3:0] v);
        logic [12:0] got;
        got = (obs_q.size() > 0) ? obs_q.pop_front() : 13'h1fff;
        check(name, 32'(got), 32'({l, v, d}));
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        obs_q.delete();
        obs_cyc.delete();
    endtask

    initial begin
        int first;
        int k;
        logic ready_ok, full_seen;
        logic [3:0] drop_before;
        int exp_coll;

        tbl[0]  = '{0, 8'h11, 1'b0, 4'b1110};
        tbl[1]  = '{0, 8'h22, 1'b0, 4'b1110};
        tbl[2]  = '{0, 8'h33, 1'b1, 4'b1110};
        tbl[3]  = '{2, 8'hA5, 1'b1, 4'b1011};
        tbl[4]  = '{1, 8'h01, 1'b0, 4'b1101};
        tbl[5]  = '{1, 8'h02, 1'b1, 4'b1101};
        tbl[6]  = '{3, 8'hFF, 1'b0, 4'b0111};
        tbl[7]  = '{3, 8'h00, 1'b0, 4'b0111};
        tbl[8]  = '{3, 8'h80, 1'b0, 4'b0111};
        tbl[9]  = '{3, 8'h7F, 1'b1, 4'b0111};
        tbl[10] = '{0, 8'hC3, 1'b1, 4'b1110};

        reset    = 1'b0;
        rx_data  = '0;
        rx_valid = '0;
        rx_last  = '0;
        tx_ready = 4'b1111;

        #12;
        check("reset_rx_ready", 32'(rx_ready), 32'h0000000f);
        check("reset_tx", 32'({tx_last, tx_valid, tx_data}), 32'h0);
        check("reset_counters", 32'({collision_cnt, drop_cnt}), 32'h0);
        apply_reset();

        // Single-port frames, one at a time
        first = 0;
        for (int i = 0; i < 11; i++) begin
            if (tbl[i].last)
                check("no_partial_fwd", 32'(obs_q.size()), 32'h0);
            push(tbl[i].port, tbl[i].data, tbl[i].last);
            if (tbl[i].last) begin
                drain(i - first + 1);
                for (int j = first; j <= i; j++)
                    expect_byte("table_byte", tbl[j].data, tbl[j].last, tbl[j].exp_valid);
                first = i + 1;
            end
        end
        check("no_collision_single", 32'(collision_cnt), 32'h0);

        // Simultaneous commit on ports 1 and 2 right after reset
        apply_reset();
        push_pair(1, 2, 8'h10, 8'h20, 1'b0);
        push_pair(1, 2, 8'h11, 8'h21, 1'b1);
        drain(4);
        check("rr_gap", 32'(obs_cyc[2] - obs_cyc[1]), 32'd3);
        expect_byte("rr_p1_b0", 8'h10, 1'b0, 4'b1101);
        expect_byte("rr_p1_b1", 8'h11, 1'b1, 4'b1101);
        expect_byte("rr_p2_b0", 8'h20, 1'b0, 4'b1011);
        expect_byte("rr_p2_b1", 8'h21, 1'b1, 4'b1011);
        check("rr_collision", 32'(collision_cnt), 32'd1);
        obs_cyc.delete();

        // Overflow on port 3: 20 bytes, only the 20th marked last
        ready_ok = 1'b1;
        full_seen = 1'b0;
        drop_before = 4'hx;
        for (int i = 0; i < 20; i++) begin
            rx_valid[3] = 1'b1;
            rx_data[31:24] = 8'hA0 + 8'(i);
            rx_last[3] = (i == 19);
            @(negedge clk);
            if (i == 16) full_seen = ~rx_ready[3];
            if (i >= 17 && !rx_ready[3]) ready_ok = 1'b0;
            if (i == 18) drop_before = drop_cnt;
            @(posedge clk); #1;
        end
        rx_valid[3] = 1'b0;
        rx_last[3] = 1'b0;
        check("drop_full_seen", 32'(full_seen), 32'd1);
        check("drop_ready_high", 32'(ready_ok), 32'd1);
        check("drop_cnt_before_last", 32'(drop_before), 32'd0);
        check("drop_cnt_after_last", 32'(drop_cnt), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        check("drop_no_egress", 32'(obs_q.size()), 32'd0);
        push(3, 8'hD0, 1'b0);
        push(3, 8'hD1, 1'b1);
        drain(2);
        expect_byte("post_drop_b0", 8'hD0, 1'b0, 4'b0111);
        expect_byte("post_drop_b1", 8'hD1, 1'b1, 4'b0111);

        // Backpressure from port 2 for three cycles mid-frame
        for (int i = 0; i < 6; i++)
            push(0, 8'h60 + 8'(i), i == 5);
        k = 0;
        @(negedge clk);
        while (tx_valid == 4'b0000 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("bp_start", 32'(tx_valid), 32'b1110);
        @(posedge clk); #1;
        tx_ready[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold", 32'({tx_last, tx_valid, tx_data}), 32'({1'b0, 4'b1110, 8'h61}));
            @(posedge clk); #1;
        end
        tx_ready[2] = 1'b1;
        drain(6);
        for (int i = 0; i < 6; i++)
            expect_byte("bp_byte", 8'h60 + 8'(i), i == 5, 4'b1110);

        // Reset mid-forward of a 10-byte frame after the 4th byte
        for (int i = 0; i < 10; i++)
            push(1, 8'h70 + 8'(i), i == 9);
        k = 0;
        while (obs_q.size() < 4 && k < 100) begin
            @(posedge clk);
            k++;
        end
        check("mid_fwd_reached", 32'(obs_q.size()), 32'd4);
        #1 reset = 1'b0;
        #1;
        check("async_rst_tx", 32'({tx_last, tx_valid, tx_data}), 32'h0);
        check("async_rst_ready", 32'(rx_ready), 32'h0000000f);
        check("async_rst_cnt", 32'({collision_cnt, drop_cnt}), 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("no_resume_after_rst", 32'(obs_q.size()), 32'd4);
        obs_q.delete();
        obs_cyc.delete();
        push(2, 8'h90, 1'b1);
        drain(1);
        expect_byte("new_frame_after_rst", 8'h90, 1'b1, 4'b1011);

        // Collision counter saturation (4-bit)
        exp_coll = 0;
        for (int r = 0; r < 17; r++) begin
            push_pair(0, 1, 8'hE0 + 8'(r), 8'hF0 + 8'(r), 1'b1);
            drain(2);
            obs_q.delete();
            obs_cyc.delete();
            exp_coll = (exp_coll == 15) ? 15 : exp_coll + 1;
            check("collision_sat", 32'(collision_cnt), 32'(exp_coll));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
